avalon_cfg_slave: RTL and testbench

// Avalon-MM slave between host CPU and the sniffer controller. Holds staging copies of
// the port/IP/MAC/URL match patterns and commits them to the comparator-facing active

---
 rtl/eth_sniffer_pkg.sv | 32 +++
 rtl/hit_read_latch.sv | 37 +++
 rtl/avalon_cfg_slave.sv | 185 ++++++++++++++++++
 tb/tb_avalon_cfg_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// rtl/eth_sniffer_pkg.sv - shared register map, widths and commit FSM states for the sniffer config slave
//
// Purpose: common constants for avalon_cfg_slave and hit_read_latch.
// Ports: none (package).

package eth_sniffer_pkg;

  // Pattern widths
  localparam int PORT_W = 16;
  localparam int IP_W   = 32;
  localparam int MAC_W  = 48;
  localparam int CNT_W  = 64;

  // Word-address register map
  localparam int unsigned ADDR_CTRL     = 32'h00;
  localparam int unsigned ADDR_PORT     = 32'h01;
  localparam int unsigned ADDR_IP       = 32'h02;
  localparam int unsigned ADDR_MAC_LO   = 32'h03;
  localparam int unsigned ADDR_MAC_HI   = 32'h04;
  localparam int unsigned ADDR_URL_LEN  = 32'h05;
  localparam int unsigned ADDR_URL_BASE = 32'h08;
  localparam int unsigned ADDR_HIT_BASE = 32'h10;
  localparam int          NUM_HITS      = 4;

  // Commit handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/hit_read_latch.sv
// rtl/hit_read_latch.sv - coherent 32-bit access to one 64-bit hit counter
//
// Purpose: a LO read returns count[31:0] and captures count[63:32] into a
// shadow on the same edge; a HI read returns that shadow, so LO-then-HI
// yields a consistent 64-bit snapshot even if the counter moves between them.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   count        live 64-bit counter
//   rd_lo        read strobe qualified for this counter's LO address
//   rd_hi        read strobe qualified for this counter's HI address
//   rd_word      read word (0 when neither strobe is active)

module hit_read_latch
  import eth_sniffer_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic [CNT_W-1:0] count,
  input  logic             rd_lo,
  input  logic             rd_hi,
  output logic [31:0]      rd_word
);

  logic [31:0] shadow;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow <= 32'h0;
    end else if (rd_lo) begin
      shadow <= count[CNT_W-1:32];
    end
  end

  // Zero when not selected so the top can OR all instances together.
  assign rd_word = rd_lo ? count[31:0] : (rd_hi ? shadow : 32'h0);

endmodule

// File: rtl/avalon_cfg_slave.sv
// rtl/avalon_cfg_slave.sv - Avalon-MM slave staging and committing sniffer match patterns
//
// Purpose: host writes staging copies of port/IP/MAC/URL patterns; a CTRL
// commit arms a handshake that copies staging to the active (comparator
// facing) registers once the controller requests a load or is idle. Also
// exposes four 64-bit hit counters as LO/HI register pairs.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   address/read/write    Avalon word address and strobes
//   writedata/readdata    Avalon data; readdata has fixed latency 1
//   load_req              controller asks for pattern load
//   cmp_busy              comparison in progress; defers commits without load_req
//   update_done           one-cycle pulse when a load_req-driven commit lands
//   *_hits                64-bit hit counters from the controller
//   cfg_port/ip/mac/url   active patterns (URL byte 0 in [7:0])
//   cfg_url_len           active URL length in bytes
//   cfg_valid             set after the first completed commit

module avalon_cfg_slave
  import eth_sniffer_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int URL_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic                   load_req,
  input  logic                   cmp_busy,
  output logic                   update_done,
  input  logic [63:0]            port_hits,
  input  logic [63:0]            ip_hits,
  input  logic [63:0]            mac_hits,
  input  logic [63:0]            url_hits,
  output logic [PORT_W-1:0]      cfg_port,
  output logic [IP_W-1:0]        cfg_ip,
  output logic [MAC_W-1:0]       cfg_mac,
  output logic [8*URL_BYTES-1:0] cfg_url,
  output logic [5:0]             cfg_url_len,
  output logic                   cfg_valid
);

  localparam int URL_WORDS = URL_BYTES / 4;
  localparam int URL_W     = 8 * URL_BYTES;

  logic [31:0] addr_w;
  assign addr_w = 32'(address);

  cfg_state_t state;
  logic       busy;
  logic       commit_wr;

  assign busy      = (state != IDLE);
  assign commit_wr = write && (addr_w == ADDR_CTRL) && writedata[0];

  // Staging registers and their next values. The next values feed the
  // commit copy so a staging write in the PEND-exit cycle is included.
  logic [PORT_W-1:0] stg_port, stg_port_nxt;
  logic [IP_W-1:0]   stg_ip,   stg_ip_nxt;
  logic [MAC_W-1:0]  stg_mac,  stg_mac_nxt;
  logic [URL_W-1:0]  stg_url,  stg_url_nxt;
  logic [5:0]        stg_len,  stg_len_nxt;

  always_comb begin
    stg_port_nxt = stg_port;
    stg_ip_nxt   = stg_ip;
    stg_mac_nxt  = stg_mac;
    stg_url_nxt  = stg_url;
    stg_len_nxt  = stg_len;
    if (write) begin
      case (addr_w)
        ADDR_PORT:   stg_port_nxt = writedata[PORT_W-1:0];
        ADDR_IP:     stg_ip_nxt   = writedata[IP_W-1:0];
        ADDR_MAC_LO: stg_mac_nxt[31:0]      = writedata;
        ADDR_MAC_HI: stg_mac_nxt[MAC_W-1:32] = writedata[MAC_W-33:0];
        ADDR_URL_LEN: begin
          if (writedata > 32'(URL_BYTES)) stg_len_nxt = 6'(URL_BYTES);
          else                            stg_len_nxt = writedata[5:0];
        end
        default: ;
      endcase
      for (int i = 0; i < URL_WORDS; i++) begin
        if (addr_w == ADDR_URL_BASE + 32'(i)) stg_url_nxt[32*i +: 32] = writedata;
      end
    end
  end

  // Hit counter read latches
  logic [63:0] hit_cnt  [NUM_HITS];
  logic [31:0] hit_word [NUM_HITS];
  logic [31:0] hit_rd;

  assign hit_cnt[0] = port_hits;
  assign hit_cnt[1] = ip_hits;
  assign hit_cnt[2] = mac_hits;
  assign hit_cnt[3] = url_hits;

  for (genvar g = 0; g < NUM_HITS; g++) begin : g_hit
    hit_read_latch u_hit (
      .clk     (clk),
      .n_rst   (n_rst),
      .count   (hit_cnt[g]),
      .rd_lo   (read && (addr_w == ADDR_HIT_BASE + 32'(2*g))),
      .rd_hi   (read && (addr_w == ADDR_HIT_BASE + 32'(2*g + 1))),
      .rd_word (hit_word[g])
    );
  end

  always_comb begin
    hit_rd = 32'h0;
    for (int i = 0; i < NUM_HITS; i++) hit_rd = hit_rd | hit_word[i];
  end

  // Read mux; pattern registers read back their staging value.
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'h0;
    case (addr_w)
      ADDR_CTRL:    rd_mux = {30'h0, cfg_valid, busy};
      ADDR_PORT:    rd_mux = 32'(stg_port);
      ADDR_IP:      rd_mux = 32'(stg_ip);
      ADDR_MAC_LO:  rd_mux = stg_mac[31:0];
      ADDR_MAC_HI:  rd_mux = 32'(stg_mac[MAC_W-1:32]);
      ADDR_URL_LEN: rd_mux = 32'(stg_len);
      default:      rd_mux = hit_rd;
    endcase
    for (int i = 0; i < URL_WORDS; i++) begin
      if (addr_w == ADDR_URL_BASE + 32'(i)) rd_mux = stg_url[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      readdata    <= 32'h0;
      state       <= IDLE;
      update_done <= 1'b0;
      stg_port    <= '0;
      stg_ip      <= '0;
      stg_mac     <= '0;
      stg_url     <= '0;
      stg_len     <= '0;
      cfg_port    <= '0;
      cfg_ip      <= '0;
      cfg_mac     <= '0;
      cfg_url     <= '0;
      cfg_url_len <= '0;
      cfg_valid   <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;

      stg_port <= stg_port_nxt;
      stg_ip   <= stg_ip_nxt;
      stg_mac  <= stg_mac_nxt;
      stg_url  <= stg_url_nxt;
      stg_len  <= stg_len_nxt;

      update_done <= 1'b0;
      case (state)
        IDLE: if (commit_wr) state <= PEND;
        PEND: begin
          // A load request commits even mid-comparison; otherwise wait for idle.
          if (load_req || !cmp_busy) begin
            state       <= DONE;
            cfg_port    <= stg_port_nxt;
            cfg_ip      <= stg_ip_nxt;
            cfg_mac     <= stg_mac_nxt;
            cfg_url     <= stg_url_nxt;
            cfg_url_len <= stg_len_nxt;
            cfg_valid   <= 1'b1;
            // Only acknowledge when the controller actually asked.
            update_done <= load_req;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_cfg_slave.sv
// tb/tb_avalon_cfg_slave.sv - self-checking bench for avalon_cfg_slave with a register-file reference model

module tb_avalon_cfg_slave;

  localparam int URL_BYTES = 16;
  localparam int URL_WORDS = URL_BYTES / 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [4:0]   address;
  logic         read, write;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         load_req, cmp_busy;
  logic         update_done;
  logic [63:0]  hits [4];
  logic [15:0]  cfg_port;
  logic [31:0]  cfg_ip;
  logic [47:0]  cfg_mac;
  logic [127:0] cfg_url;
  logic [5:0]   cfg_url_len;
  logic         cfg_valid;

  always #5 clk = ~clk;

  avalon_cfg_slave #(.ADDR_W(5), .URL_BYTES(URL_BYTES)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .load_req    (load_req),
    .cmp_busy    (cmp_busy),
    .update_done (update_done),
    .port_hits   (hits[0]),
    .ip_hits     (hits[1]),
    .mac_hits    (hits[2]),
    .url_hits    (hits[3]),
    .cfg_port    (cfg_port),
    .cfg_ip      (cfg_ip),
    .cfg_mac     (cfg_mac),
    .cfg_url     (cfg_url),
    .cfg_url_len (cfg_url_len),
    .cfg_valid   (cfg_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // Reference model: register file indexed by word address.
  logic [31:0] stg [32];
  logic [31:0] act [32];
  logic [31:0] shadow [4];
  int          phase;      // 0 idle, 1 waiting to commit, 2 commit just landed
  logic        m_valid, m_done;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      stg[i] = 32'h0;
      act[i] = 32'h0;
    end
    for (int i = 0; i < 4; i++) shadow[i] = 32'h0;
    phase   = 0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_rdata = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return {30'h0, m_valid, 1'b0} | ((phase != 0) ? 32'h1 : 32'h0);
    if ((a >= 1 && a <= 5) || (a >= 8 && a < 8 + URL_WORDS)) return stg[a];
    if (a >= 16 && a < 24) begin
      if (a % 2 == 0) return hits[(a - 16) / 2][31:0];
      return shadow[(a - 16) / 2];
    end
    return 32'h0;
  endfunction

  task automatic model_step(input bit rd, input bit wr, input int a, input logic [31:0] wd);
    if (rd) begin
      m_rdata = model_read(a);
      if (a >= 16 && a < 24 && a % 2 == 0) shadow[(a - 16) / 2] = hits[(a - 16) / 2][63:32];
    end
    if (wr) begin
      if (a == 1 || a == 4)                 stg[a] = wd & 32'hFFFF;
      else if (a == 2 || a == 3)            stg[a] = wd;
      else if (a == 5)                      stg[a] = (wd > URL_BYTES) ? URL_BYTES : wd;
      else if (a >= 8 && a < 8 + URL_WORDS) stg[a] = wd;
    end
    m_done = 1'b0;
    if (phase == 1 && (load_req || !cmp_busy)) begin
      for (int i = 0; i < 32; i++) act[i] = stg[i];
      m_valid = 1'b1;
      m_done  = load_req;
      phase   = 2;
    end else if (phase == 2) begin
      phase = 0;
    end else if (phase == 0 && wr && a == 0 && wd[0]) begin
      phase = 1;
    end
  endtask

  task automatic check_outputs();
    check("readdata", readdata, m_rdata);
    check("update_done", update_done, m_done);
    check("cfg_port", cfg_port, act[1][15:0]);
    check("cfg_ip", cfg_ip, act[2]);
    check("cfg_mac", cfg_mac, {act[4][15:0], act[3]});
    check("cfg_url", cfg_url, {act[11], act[10], act[9], act[8]});
    check("cfg_url_len", cfg_url_len, act[5][5:0]);
    check("cfg_valid", cfg_valid, m_valid);
  endtask

  task automatic cycle(input bit rd, input bit wr, input int a, input logic [31:0] wd);
    read      = rd;
    write     = wr;
    address   = 5'(a);
    writedata = wd;
    model_step(rd, wr, a, wd);
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    check_outputs();
    if (update_done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; address = '0; read = 0; write = 0; writedata = '0;
    load_req = 0; cmp_busy = 0;
    for (int i = 0; i < 4; i++) hits[i] = 64'h0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    n_rst = 1'b1;

    // 1: commit with load_req, pulse in cycle k+2
    load_req = 1; cmp_busy = 0;
    cycle(0, 1, 1, 32'h0050);
    cycle(0, 1, 2, 32'hC0A80001);
    cycle(0, 1, 0, 32'h1);
    check("t1_done_k1", update_done, 1'b0);
    idle(1);
    check("t1_done_k2", update_done, 1'b1);
    check("t1_port", cfg_port, 16'h0050);
    check("t1_ip", cfg_ip, 32'hC0A80001);
    idle(1);
    cycle(1, 0, 0, 32'h0);
    check("t1_ctrl", readdata, 32'h2);

    // 2: deferred by cmp_busy, no pulse without load_req
    load_req = 0; cmp_busy = 1;
    cycle(0, 1, 1, 32'h1234);
    cycle(0, 1, 0, 32'h1);
    idle(3);
    cycle(1, 0, 0, 32'h0);
    check("t2_ctrl_busy", readdata, 32'h3);
    check("t2_port_held", cfg_port, 16'h0050);
    cmp_busy = 0; done_seen = 0;
    idle(1);
    check("t2_port_loaded", cfg_port, 16'h1234);
    idle(2);
    check("t2_no_done", done_seen, 0);

    // 3: coherent hit counter pair
    hits[0] = 64'h1_FFFFFFFF;
    cycle(1, 0, 16, 32'h0);
    check("t3_lo", readdata, 32'hFFFFFFFF);
    hits[0] = 64'h2_00000000;
    cycle(1, 0, 17, 32'h0);
    check("t3_hi", readdata, 32'h1);

    // 4: staging write during PEND lands, second commit ignored
    load_req = 0; cmp_busy = 1; done_seen = 0;
    cycle(0, 1, 0, 32'h1);
    cycle(0, 1, 1, 32'h01BB);
    cycle(0, 1, 0, 32'h1);
    load_req = 1;
    idle(4);
    check("t4_port", cfg_port, 16'h01BB);
    check("t4_one_done", done_seen, 1);

    // 5: reset during PEND, then load_req alone does nothing
    load_req = 0; cmp_busy = 1;
    cycle(0, 1, 0, 32'h1);
    idle(1);
    async_reset();
    check("t5_port0", cfg_port, 16'h0);
    check("t5_valid0", cfg_valid, 1'b0);
    cmp_busy = 0; load_req = 1; done_seen = 0;
    idle(4);
    check("t5_no_done", done_seen, 0);
    check("t5_still_invalid", cfg_valid, 1'b0);

    // 6: unmapped, hit-counter write ignored, length saturation
    cycle(1, 0, 31, 32'h0);
    check("t6_unmapped", readdata, 32'h0);
    hits[0] = 64'h5_0000BEEF;
    cycle(0, 1, 16, 32'hDEAD);
    cycle(1, 0, 16, 32'h0);
    check("t6_hit_live", readdata, 32'h0000BEEF);
    cycle(0, 1, 5, 32'd40);
    cycle(1, 0, 5, 32'h0);
    check("t6_len_sat", readdata, URL_BYTES);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int a;
      logic [31:0] wd;
      load_req = ($urandom % 4) == 0;
      cmp_busy = ($urandom % 3) != 0;
      if (i % 16 == 0) for (int h = 0; h < 4; h++) hits[h] = {$urandom, $urandom};
      case ($urandom % 4)
        0:       a = 0;
        1:       a = 16 + ($urandom % 8);
        2:       a = 1 + ($urandom % 11);
        default: a = $urandom % 32;
      endcase
      wd = $urandom;
      if (a == 5 && ($urandom % 2)) wd = $urandom % 24;
      cycle(1'($urandom % 2), 1'($urandom % 2), a, wd);
      if (i == 400) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
